avg_win_ctrl: RTL and testbench
===============================

// Module: avg_win_ctrl
// PURPOSE
//  Sliding-window controller for the closest-to-average filter. Takes one
//  sample per valid/ready handshake, keeps the last N in a circular buffer
//  with a running sum, then scans the window one entry per cycle. Emits the
//  sample closest to floor(sum/N). Sits between the sample source and the
//  result consumer, sequencing buffer, adder and comparator over time.
// PARAMETERS
//  DW  16  sample/result width, unsigned
//  N   12  window depth (>=2); sum width SW = DW+$clog2(N)
// PORTS
//  clk        in   1      single clock, all logic on rising edge
//  reset      in   1      synchronous, active-low; clears all state
//  din        in   DW     input sample
//  din_valid  in   1      din is valid
//  din_ready  out  1      block can accept; transfer = din_valid & din_ready
//  dout       out  DW     selected window sample; holds until next result
//  dout_valid out  1      1-cycle pulse with new dout; no backpressure
//  busy       out  1      high in AVG/SCAN/OUT
//  fill_cnt   out  4      samples held, saturates at N
// BEHAVIOUR
//  Reset (reset==0 at edge): state=FILL, wp=0, sum=0, fill_cnt=0, dout=0,
//   dout_valid=0. Buffer contents are don't-care.
//  din_ready = (state==FILL)|(state==WAIT). Decoded from state only.
//  FILL: on transfer, buf[wp]<=din, sum+=din, wp++, fill_cnt++.
//   The N-th transfer goes to AVG; earlier transfers stay in FILL.
//  WAIT (window full): on transfer, sum <= sum - buf[wp] + din,
//   buf[wp]<=din, wp++ -> AVG. Oldest sample is overwritten.
//  wp wraps N-1 -> 0. fill_cnt never exceeds N. sum never overflows SW.
//  AVG (1 cycle): avg <= floor(sum/N), truncated to DW.
//   Init best_dist = all-ones, si = wp (oldest entry) -> SCAN.
//  SCAN (N cycles, scanning oldest to newest, si wrapping):
//   s = buf[si]; d = |s - avg|.
//   If s <= avg: take s when d <= best_dist.
//   If s >  avg: take s only when d <  best_dist.
//   Take = best<=s, best_dist<=d. After the N-th entry -> OUT.
//  OUT (1 cycle): dout<=best, dout_valid=1 -> WAIT.
//  Latency: accepting transfer at edge t gives dout_valid high in cycle
//   t+N+2. One result per full-window transfer.
//  Max throughput: one sample per N+3 cycles.
//  Backpressure: din_valid held during AVG/SCAN/OUT is neither lost nor
//   duplicated. It is taken on the first WAIT cycle.
//  Reset mid-operation overrides everything. An in-flight scan is aborted
//   and no dout_valid is produced.
// CONFIGURATION
//  AVG_WIN_CTRL_FLUSH_EN defined: adds input port flush (1 bit).
//   flush=1 in FILL/WAIT: next cycle state=FILL, wp=0, sum=0, fill_cnt=0,
//   dout unchanged. A din transfer in the same cycle is discarded.
//   flush in AVG/SCAN/OUT is ignored; the result completes normally.
//  Not defined: no flush port; the window clears only on reset.
// TESTING (N=12, DW=16)
//  T1 feed 1..12 back-to-back -> one dout_valid, dout=6 (sum 78, avg 6),
//     12+2 cycles after last transfer; fill_cnt=12.
//  T2 after T1 feed 25 -> window 2..12,25, sum 102, avg 8 -> dout=8.
//  T3 fresh: six 4s then six 8s -> avg 6, tie dist 2 -> dout=4.
//     Alternate 8,4 x6 -> dout=4.
//  T4 din_valid held high with incrementing data through SCAN ->
//     din_ready=0 in AVG/SCAN/OUT. Each sample accepted exactly once, in
//     order; dout_valid count equals accepted count minus 11.
//  T5 assert reset low during SCAN -> no dout_valid pulse; dout=0,
//     fill_cnt=0, din_ready=1 next cycle. Refill 1..12 -> dout=6.
//  T6 (FLUSH_EN) fill 5 samples, pulse flush -> fill_cnt=0.
//     Then 12x100 -> dout=100. A flush pulse during SCAN leaves the result
//     intact.

Source files
------------

// File: rtl/avg_win_ctrl.sv
// avg_win_ctrl: sliding-window closest-to-average selector.
// Optional feature: define AVG_WIN_CTRL_FLUSH_EN to add a flush input
// that clears the window while idle in FILL/WAIT.
module avg_win_ctrl #(
    parameter int DW = 16,
    parameter int N  = 12
) (
    input  logic          clk,
    input  logic          reset,
`ifdef AVG_WIN_CTRL_FLUSH_EN
    input  logic          flush,
`endif
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          busy,
    output logic [3:0]    fill_cnt
);
    localparam int SW = DW + $clog2(N);
    localparam int AW = $clog2(N);
    localparam logic [2:0] FILL = 3'd0;
    localparam logic [2:0] WAIT = 3'd1;
    localparam logic [2:0] AVG  = 3'd2;
    localparam logic [2:0] SCAN = 3'd3;
    localparam logic [2:0] OUT  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] wp_q, wp_d, si_q, si_d, cnt_q, cnt_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [3:0]    fill_q, fill_d;
    logic [DW-1:0] avg_q, avg_d, best_q, best_d, bd_q, bd_d, dout_q, dout_d;
    logic          dv_q, dv_d;
    logic [DW-1:0] mem_q [N];
    logic          flush_w, xfer;
    logic [AW-1:0] wp_inc, si_inc;
    logic [DW-1:0] s, d;
    logic          take;

`ifdef AVG_WIN_CTRL_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign din_ready  = (state_q == FILL) || (state_q == WAIT);
    assign busy       = (state_q == AVG) || (state_q == SCAN) || (state_q == OUT);
    assign xfer       = din_valid && din_ready;
    assign fill_cnt   = fill_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign wp_inc     = (wp_q == AW'(N - 1)) ? '0 : wp_q + 1'b1;
    assign si_inc     = (si_q == AW'(N - 1)) ? '0 : si_q + 1'b1;
    assign s          = mem_q[si_q];
    assign d          = (s > avg_q) ? s - avg_q : avg_q - s;
    // Ties favour samples at or below the average; later ones replace earlier.
    assign take       = (s <= avg_q) ? (d <= bd_q) : (d < bd_q);

    // Next-state sequencing of fill, average, scan and output phases.
    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        si_d    = si_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        fill_d  = fill_q;
        avg_d   = avg_q;
        best_d  = best_q;
        bd_d    = bd_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        case (state_q)
            FILL, WAIT: begin
                if (flush_w) begin
                    state_d = FILL;
                    wp_d    = '0;
                    sum_d   = '0;
                    fill_d  = '0;
                end else if (xfer) begin
                    wp_d = wp_inc;
                    if (state_q == FILL) begin
                        sum_d   = sum_q + SW'(din);
                        fill_d  = fill_q + 4'd1;
                        state_d = (fill_q == 4'(N - 1)) ? AVG : FILL;
                    end else begin
                        sum_d   = sum_q - SW'(mem_q[wp_q]) + SW'(din);
                        state_d = AVG;
                    end
                end
            end
            AVG: begin
                avg_d   = DW'(sum_q / SW'(N));
                bd_d    = '1;
                best_d  = '0;
                si_d    = wp_q;
                cnt_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                best_d  = take ? s : best_q;
                bd_d    = take ? d : bd_q;
                si_d    = si_inc;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == AW'(N - 1)) ? OUT : SCAN;
            end
            OUT: begin
                dout_d  = best_q;
                dv_d    = 1'b1;
                state_d = WAIT;
            end
            default: state_d = FILL;
        endcase
    end

    // Control and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FILL;
            wp_q    <= '0;
            si_q    <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            fill_q  <= '0;
            avg_q   <= '0;
            best_q  <= '0;
            bd_q    <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            si_q    <= si_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            fill_q  <= fill_d;
            avg_q   <= avg_d;
            best_q  <= best_d;
            bd_q    <= bd_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
        end
    end

    // Window storage; a flushed transfer is never written.
    always_ff @(posedge clk) begin
        if (xfer && !flush_w) mem_q[wp_q] <= din;
    end
endmodule

// File: tb/tb_avg_win_ctrl.sv
// tb_avg_win_ctrl: randomized self-checking bench with a window-level reference model.
module tb_avg_win_ctrl;
    localparam int DW = 16;
    localparam int N  = 12;

    typedef struct {
        logic [DW-1:0] d;
        int            c;
    } ev_t;

    logic clk = 1'b0, reset = 1'b0, din_valid = 1'b0, flush = 1'b0;
    logic [DW-1:0] din = '0;
    logic din_ready, dout_valid, busy;
    logic [DW-1:0] dout;
    logic [3:0] fill_cnt;
    int cyc = 0, checks = 0, errors = 0;
    ev_t acc_q[$], res_q[$], exp_q[$];
    logic [DW-1:0] win[$];

    avg_win_ctrl #(.DW(DW), .N(N)) dut (
        .clk(clk),
        .reset(reset),
`ifdef AVG_WIN_CTRL_FLUSH_EN
        .flush(flush),
`endif
        .din(din),
        .din_valid(din_valid),
        .din_ready(din_ready),
        .dout(dout),
        .dout_valid(dout_valid),
        .busy(busy),
        .fill_cnt(fill_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset && din_valid && din_ready && !flush) acc_q.push_back('{din, cyc});
        if (dout_valid) res_q.push_back('{dout, cyc});
    end

    function automatic logic [DW-1:0] closest(input logic [DW-1:0] w[$]);
        longint sum, avg, bd, dd, sv;
        logic [DW-1:0] best;
        sum = 0;
        best = '0;
        foreach (w[i]) sum += longint'(w[i]);
        avg = sum / N;
        bd = (longint'(1) << DW) - 1;
        foreach (w[i]) begin
            sv = longint'(w[i]);
            dd = (sv > avg) ? sv - avg : avg - sv;
            if ((sv <= avg && dd <= bd) || (sv > avg && dd < bd)) begin
                best = w[i];
                bd = dd;
            end
        end
        return best;
    endfunction

    function automatic void model_drain();
        ev_t e;
        while (acc_q.size() > 0) begin
            e = acc_q.pop_front();
            win.push_back(e.d);
            if (win.size() > N) void'(win.pop_front());
            if (win.size() == N) exp_q.push_back('{closest(win), e.c + N + 3});
        end
    endfunction

    task automatic clear_model();
        acc_q.delete();
        res_q.delete();
        exp_q.delete();
        win.delete();
    endtask

    task automatic send(input logic [DW-1:0] v);
        int n;
        logic acc;
        din = v;
        din_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout value %0d not accepted within 200 cycles", v);
        end
    endtask

    task automatic settle();
        din_valid = 1'b0;
        repeat (N + 6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        din_valid = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_model();
    endtask

    task automatic test_reset();
        din_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dout, dout_valid, fill_cnt, din_ready, busy} !== {16'd0, 1'b0, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state dout=%0d dv=%0b fill=%0d rdy=%0b busy=%0b exp 0 0 0 1 0",
                     dout, dout_valid, fill_cnt, din_ready, busy);
        end
        reset = 1'b1;
        clear_model();
    endtask

    task automatic test_fill_avg();
        ev_t r, x;
        for (int i = 1; i <= 11; i++) send(DW'(i));
        checks++;
        if (fill_cnt !== 4'd11 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_partial fill=%0d busy=%0b exp 11 0", fill_cnt, busy);
        end
        send(16'd12);
        settle();
        checks++;
        if (fill_cnt !== 4'd12) begin
            errors++;
            $display("FAIL fill_full fill=%0d exp 12", fill_cnt);
        end
        checks++;
        if (res_q.size() != 1 || res_q[0].d !== 16'd6) begin
            errors++;
            $display("FAIL t1_dout count=%0d first=%0d exp 1 result of 6", res_q.size(),
                     res_q.size() ? res_q[0].d : 16'hxxxx);
        end
        send(16'd25);
        settle();
        checks++;
        if (res_q.size() != 2 || res_q[1].d !== 16'd8) begin
            errors++;
            $display("FAIL t2_dout count=%0d exp 2 results ending in 8", res_q.size());
        end
        model_drain();
        checks++;
        if (res_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL fill_count got %0d exp %0d", res_q.size(), exp_q.size());
        end
        while (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (r.d !== x.d || r.c != x.c) begin
                errors++;
                $display("FAIL fill_result got %0d@%0d exp %0d@%0d", r.d, r.c, x.d, x.c);
            end
        end
        res_q.delete();
        exp_q.delete();
    endtask

    task automatic test_tie();
        ev_t r, x;
        logic [DW-1:0] last;
        do_reset();
        for (int i = 0; i < 12; i++) send(i < 6 ? 16'd4 : 16'd8);
        settle();
        checks++;
        if (res_q.size() != 1 || res_q[0].d !== 16'd4) begin
            errors++;
            $display("FAIL t3_tie count=%0d exp single result 4", res_q.size());
        end
        for (int i = 0; i < 12; i++) send(i % 2 == 0 ? 16'd8 : 16'd4);
        settle();
        last = res_q.size() ? res_q[res_q.size() - 1].d : 16'hxxxx;
        checks++;
        if (res_q.size() != 13 || last !== 16'd4) begin
            errors++;
            $display("FAIL t3_alt count=%0d last=%0d exp 13 ending in 4", res_q.size(), last);
        end
        model_drain();
        checks++;
        if (res_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL tie_count got %0d exp %0d", res_q.size(), exp_q.size());
        end
        while (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (r.d !== x.d || r.c != x.c) begin
                errors++;
                $display("FAIL tie_result got %0d@%0d exp %0d@%0d", r.d, r.c, x.d, x.c);
            end
        end
        res_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        ev_t r, x;
        logic [DW-1:0] k, base;
        logic acc;
        int bp_bad, ord_bad, na;
        do_reset();
        base = DW'($urandom_range(100, 60000));
        k = base;
        bp_bad = 0;
        ord_bad = 0;
        for (int i = 0; i < 90; i++) begin
            din = k;
            din_valid = 1'b1;
            @(negedge clk);
            acc = din_ready;
            if (busy && din_ready) bp_bad++;
            @(posedge clk);
            #1;
            if (acc) k++;
        end
        settle();
        na = acc_q.size();
        foreach (acc_q[i]) if (acc_q[i].d !== base + DW'(i)) ord_bad++;
        checks++;
        if (bp_bad != 0) begin
            errors++;
            $display("FAIL bp_ready cycles with ready while busy=%0d exp 0", bp_bad);
        end
        checks++;
        if (ord_bad != 0 || na != int'(k - base)) begin
            errors++;
            $display("FAIL bp_order misordered=%0d accepted=%0d exp 0 and %0d", ord_bad, na, k - base);
        end
        checks++;
        if (res_q.size() != na - (N - 1)) begin
            errors++;
            $display("FAIL bp_results got %0d exp %0d", res_q.size(), na - (N - 1));
        end
        model_drain();
        while (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (r.d !== x.d || r.c != x.c) begin
                errors++;
                $display("FAIL bp_result got %0d@%0d exp %0d@%0d", r.d, r.c, x.d, x.c);
            end
        end
        res_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        ev_t r, x;
        send(16'd3);
        din_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || dout === 16'd0) begin
            errors++;
            $display("FAIL t5_pre busy=%0b dout=%0d exp busy 1 and nonzero dout", busy, dout);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        checks++;
        if ({dout, fill_cnt, din_ready, dout_valid} !== {16'd0, 4'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL t5_reset dout=%0d fill=%0d rdy=%0b dv=%0b exp 0 0 1 0",
                     dout, fill_cnt, din_ready, dout_valid);
        end
        repeat (N + 6) @(posedge clk);
        #1;
        checks++;
        if (res_q.size() != 0) begin
            errors++;
            $display("FAIL t5_no_pulse results=%0d exp 0", res_q.size());
        end
        clear_model();
        for (int i = 1; i <= 12; i++) send(DW'(i));
        settle();
        model_drain();
        checks++;
        if (res_q.size() != 1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL t5_refill_count got %0d exp 1", res_q.size());
        end
        while (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (r.d !== 16'd6 || r.d !== x.d || r.c != x.c) begin
                errors++;
                $display("FAIL t5_refill got %0d@%0d exp 6@%0d", r.d, r.c, x.c);
            end
        end
        res_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        ev_t r, x;
        int bad;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            send(DW'($urandom_range(0, 65535)));
            if ($urandom_range(0, 2) == 0) begin
                din_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        settle();
        model_drain();
        checks++;
        if (res_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count got %0d exp %0d", res_q.size(), exp_q.size());
        end
        bad = 0;
        while (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (r.d !== x.d || r.c != x.c) begin
                errors++;
                if (bad++ < 5) $display("FAIL rand_result got %0d@%0d exp %0d@%0d", r.d, r.c, x.d, x.c);
            end
        end
        res_q.delete();
        exp_q.delete();
    endtask

`ifdef AVG_WIN_CTRL_FLUSH_EN
    task automatic test_flush();
        ev_t r, x;
        do_reset();
        for (int i = 0; i < 5; i++) send(DW'($urandom_range(1, 50)));
        din = 16'd999;
        din_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        din_valid = 1'b0;
        model_drain();
        win.delete();
        checks++;
        if (fill_cnt !== 4'd0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL t6_flush fill=%0d rdy=%0b exp 0 1", fill_cnt, din_ready);
        end
        for (int i = 0; i < 12; i++) send(16'd100);
        settle();
        send(16'd7);
        din_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        settle();
        checks++;
        if (fill_cnt !== 4'd12 || res_q.size() != 2 || res_q[0].d !== 16'd100) begin
            errors++;
            $display("FAIL t6_scan_flush fill=%0d results=%0d exp 12 and 2 results starting 100",
                     fill_cnt, res_q.size());
        end
        model_drain();
        while (res_q.size() > 0 && exp_q.size() > 0) begin
            r = res_q.pop_front();
            x = exp_q.pop_front();
            checks++;
            if (r.d !== x.d || r.c != x.c) begin
                errors++;
                $display("FAIL flush_result got %0d@%0d exp %0d@%0d", r.d, r.c, x.d, x.c);
            end
        end
        res_q.delete();
        exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_fill_avg();
        test_tie();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef AVG_WIN_CTRL_FLUSH_EN
        test_flush();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
